// File: rtl/emulib_rammodel_timing_model_latency.sv
// Fixed-latency AXI timing model: times R bursts and B responses from AR/AW/W control traffic (IDs only, no data).
// Latency: first R beat R_LATENCY cycles after AR, B W_LATENCY cycles after wlast, in-order per channel.
// Backpressure: arready/awready drop when the per-channel queue is full; R/B outputs hold until rready/bready.
module emulib_rammodel_timing_model_latency #(
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int MAX_R_INFLIGHT = 8,
  parameter int MAX_W_INFLIGHT = 8,
  parameter int R_LATENCY      = 20,
  parameter int W_LATENCY      = 20,
  parameter int TS_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // read address channel
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  // write address channel
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  // write data channel (data itself is not modelled)
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  // write response channel
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_WIDTH-1:0]   bid,
  // read data channel (timing and IDs only)
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic                  rlast
);

  localparam int RPW = $clog2(MAX_R_INFLIGHT);
  localparam int WPW = $clog2(MAX_W_INFLIGHT);

  localparam logic [TS_WIDTH-1:0] R_LAT  = TS_WIDTH'(R_LATENCY);
  localparam logic [TS_WIDTH-1:0] W_LAT  = TS_WIDTH'(W_LATENCY);
  localparam logic [RPW:0]        R_FULL = (RPW + 1)'(MAX_R_INFLIGHT);
  localparam logic [WPW:0]        W_FULL = (WPW + 1)'(MAX_W_INFLIGHT);

  // Address, size, burst and awlen play no part in timing.
  logic unused_ok;
  assign unused_ok = ^{araddr, arsize, arburst, awaddr, awlen, awsize, awburst};

  // --------------------------------------------------------------------------
  // Free-running timestamp
  // --------------------------------------------------------------------------
  logic [TS_WIDTH-1:0] now_q, now_d;

  assign now_d = now_q + TS_WIDTH'(1);

  // --------------------------------------------------------------------------
  // Read queue: {id, len, t}, circular, registered occupancy count
  // --------------------------------------------------------------------------
  logic [ID_WIDTH-1:0] r_id_q  [MAX_R_INFLIGHT];
  logic [7:0]          r_len_q [MAX_R_INFLIGHT];
  logic [TS_WIDTH-1:0] r_t_q   [MAX_R_INFLIGHT];

  logic [RPW-1:0] r_wr_q, r_wr_d;
  logic [RPW-1:0] r_rd_q, r_rd_d;
  logic [RPW:0]   r_count_q, r_count_d;
  logic [7:0]     beat_q, beat_d;

  logic [TS_WIDTH-1:0] r_age;
  logic                r_head_due;
  logic                ar_hs;
  logic                r_hs;
  logic                r_pop;

  // Wrap-safe due test: head is due once now has reached or passed its t.
  assign r_age      = now_q - r_t_q[r_rd_q];
  assign r_head_due = ~r_age[TS_WIDTH-1];

  assign arready = (r_count_q != R_FULL);
  assign rvalid  = (r_count_q != '0) && r_head_due;
  assign rid     = r_id_q[r_rd_q];
  assign rlast   = rvalid && (beat_q == r_len_q[r_rd_q]);

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  assign r_pop = r_hs && rlast;

  // Read pointers, occupancy and beat counter next state; push and pop may coincide.
  always_comb begin
    r_wr_d    = r_wr_q;
    r_rd_d    = r_rd_q;
    r_count_d = r_count_q;
    beat_d    = beat_q;
    if (ar_hs) begin
      r_wr_d = r_wr_q + RPW'(1);
    end
    if (r_pop) begin
      r_rd_d = r_rd_q + RPW'(1);
    end
    case ({ar_hs, r_pop})
      2'b10:   r_count_d = r_count_q + (RPW + 1)'(1);
      2'b01:   r_count_d = r_count_q - (RPW + 1)'(1);
      default: r_count_d = r_count_q;
    endcase
    if (r_hs) begin
      beat_d = rlast ? 8'd0 : beat_q + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Write queue: {id, t, done}, pointers carry an extra wrap bit so a full
  // queue of entries still awaiting data is distinguishable from empty.
  // --------------------------------------------------------------------------
  logic [ID_WIDTH-1:0]       w_id_q [MAX_W_INFLIGHT];
  logic [TS_WIDTH-1:0]       w_t_q  [MAX_W_INFLIGHT];
  logic [MAX_W_INFLIGHT-1:0] w_done_q, w_done_d;

  logic [WPW:0] aw_ptr_q, aw_ptr_d;
  logic [WPW:0] w_ptr_q,  w_ptr_d;
  logic [WPW:0] b_ptr_q,  b_ptr_d;

  logic [WPW:0]        w_count;
  logic [WPW-1:0]      aw_idx, w_idx, b_idx;
  logic [TS_WIDTH-1:0] b_age;
  logic                b_head_due;
  logic                aw_hs;
  logic                w_done_hs;
  logic                b_hs;

  assign aw_idx  = aw_ptr_q[WPW-1:0];
  assign w_idx   = w_ptr_q[WPW-1:0];
  assign b_idx   = b_ptr_q[WPW-1:0];
  assign w_count = aw_ptr_q - b_ptr_q;

  assign b_age      = now_q - w_t_q[b_idx];
  assign b_head_due = ~b_age[TS_WIDTH-1];

  assign awready = (w_count != W_FULL);
  // Data is only taken for an AW that has been accepted but not yet completed.
  assign wready  = (w_ptr_q != aw_ptr_q);
  assign bvalid  = (w_count != '0) && w_done_q[b_idx] && b_head_due;
  assign bid     = w_id_q[b_idx];

  assign aw_hs     = awvalid && awready;
  assign w_done_hs = wvalid && wready && wlast;
  assign b_hs      = bvalid && bready;

  // Write pointers and done flags; push, completion and pop always touch distinct entries.
  always_comb begin
    aw_ptr_d = aw_ptr_q;
    w_ptr_d  = w_ptr_q;
    b_ptr_d  = b_ptr_q;
    w_done_d = w_done_q;
    if (aw_hs) begin
      aw_ptr_d         = aw_ptr_q + (WPW + 1)'(1);
      w_done_d[aw_idx] = 1'b0;
    end
    if (w_done_hs) begin
      w_ptr_d         = w_ptr_q + (WPW + 1)'(1);
      w_done_d[w_idx] = 1'b1;
    end
    if (b_hs) begin
      b_ptr_d         = b_ptr_q + (WPW + 1)'(1);
      w_done_d[b_idx] = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------

  // Control state with synchronous reset; dropping pointers discards all in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      now_q     <= '0;
      r_wr_q    <= '0;
      r_rd_q    <= '0;
      r_count_q <= '0;
      beat_q    <= '0;
      aw_ptr_q  <= '0;
      w_ptr_q   <= '0;
      b_ptr_q   <= '0;
      w_done_q  <= '0;
    end else begin
      now_q     <= now_d;
      r_wr_q    <= r_wr_d;
      r_rd_q    <= r_rd_d;
      r_count_q <= r_count_d;
      beat_q    <= beat_d;
      aw_ptr_q  <= aw_ptr_d;
      w_ptr_q   <= w_ptr_d;
      b_ptr_q   <= b_ptr_d;
      w_done_q  <= w_done_d;
    end
  end

  // Queue payloads; contents are only meaningful between valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      r_id_q[r_wr_q]  <= arid;
      r_len_q[r_wr_q] <= arlen;
      r_t_q[r_wr_q]   <= now_q + R_LAT;
    end
    if (aw_hs) begin
      w_id_q[aw_idx] <= awid;
    end
    if (w_done_hs) begin
      w_t_q[w_idx] <= now_q + W_LAT;
    end
  end

endmodule

// File: tb/tb_emulib_rammodel_timing_model_latency.sv
module tb_emulib_rammodel_timing_model_latency;

  localparam int IDW = 4;
  localparam int AW  = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           arvalid, arready;
  logic [IDW-1:0] arid;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           awvalid, awready;
  logic [IDW-1:0] awid;
  logic [AW-1:0]  awaddr;
  logic [7:0]     awlen;
  logic [2:0]     awsize;
  logic [1:0]     awburst;
  logic           wvalid, wready, wlast;
  logic           bvalid, bready;
  logic [IDW-1:0] bid;
  logic           rvalid, rready, rlast;
  logic [IDW-1:0] rid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  // Narrow timestamp so the wrap case is reachable in a short run.
  emulib_rammodel_timing_model_latency #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .MAX_R_INFLIGHT(8), .MAX_W_INFLIGHT(8),
    .R_LATENCY(20), .W_LATENCY(20), .TS_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rlast(rlast)
  );

  // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic until_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    logic seen;
    int   rel;

    rst = 1'b1;
    arvalid = 1'b0; arid = '0; araddr = 32'h1000; arlen = '0; arsize = 3'd2; arburst = 2'd1;
    awvalid = 1'b0; awid = '0; awaddr = 32'h2000; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1;
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b0; rready = 1'b0;

    step();
    step();
    rst = 1'b0;
    cyc = 0;  // now == 0 in this cycle

    // Reset values
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_wready",  wready,  0);
    chk("rst_rvalid",  rvalid,  0);
    chk("rst_rlast",   rlast,   0);
    chk("rst_bvalid",  bvalid,  0);

    // Single 4-beat read: AR at cycle 10 -> beats at cycles 30..33
    until_cyc(10);
    arvalid = 1'b1; arid = 4'd5; arlen = 8'd3;
    chk("r1_arready", arready, 1);
    step();
    arvalid = 1'b0;
    rready  = 1'b1;
    seen = 1'b0;
    while (cyc < 30) begin
      if (rvalid) seen = 1'b1;
      step();
    end
    chk("r1_no_early", seen, 0);
    for (int b = 0; b < 4; b++) begin
      chk("r1_rvalid", rvalid, 1);
      chk("r1_rid",    rid,    5);
      chk("r1_rlast",  rlast,  (b == 3) ? 1 : 0);
      step();
    end
    chk("r1_done", rvalid, 0);

    // Read queue depth: 9 back-to-back 2-beat ARs from cycle 40, rready low
    rready = 1'b0;
    until_cyc(40);
    arvalid = 1'b1; arlen = 8'd1;
    for (int k = 0; k < 9; k++) begin
      arid = k[IDW-1:0];
      chk("r2_arready_fill", arready, (k < 8) ? 1 : 0);
      if (k < 8) step();
    end
    until_cyc(60);
    chk("r2_head_rvalid", rvalid, 1);
    chk("r2_head_rid",    rid,    0);
    chk("r2_head_rlast",  rlast,  0);
    until_cyc(64);
    chk("r2_hold_rvalid",  rvalid,  1);
    chk("r2_hold_rid",     rid,     0);
    chk("r2_hold_arready", arready, 0);
    until_cyc(65);
    rready = 1'b1;
    chk("r2_b0_rid",   rid,   0);
    chk("r2_b0_rlast", rlast, 0);
    step();
    chk("r2_b1_rlast",       rlast,   1);
    chk("r2_b1_rid",         rid,     0);
    chk("r2_arready_same",   arready, 0);
    step();
    chk("r2_arready_freed",  arready, 1);
    // 9th AR (id 8) handshakes at cycle 67 -> due at cycle 87
    for (rel = 2; rel <= 25; rel++) begin
      if (rel <= 15) begin
        chk("r2_seq_rvalid", rvalid, 1);
        chk("r2_seq_rid",    rid,    rel / 2);
        chk("r2_seq_rlast",  rlast,  rel % 2);
      end else if (rel == 22 || rel == 23) begin
        chk("r2_ninth_rvalid", rvalid, 1);
        chk("r2_ninth_rid",    rid,    8);
        chk("r2_ninth_rlast",  rlast,  (rel == 23) ? 1 : 0);
      end else begin
        chk("r2_gap_rvalid", rvalid, 0);
      end
      step();
      arvalid = 1'b0;
    end

    // Write: W pending before AW stalls; AW at 100, beats 101..104, B at 124
    until_cyc(98);
    wvalid = 1'b1; wlast = 1'b0;
    chk("w_pre_aw_wready", wready, 0);
    step();
    chk("w_pre_aw_wready", wready, 0);
    step();
    awvalid = 1'b1; awid = 4'd3;
    chk("w_awready", awready, 1);
    chk("w_pre_aw_wready", wready, 0);
    step();
    awvalid = 1'b0;
    while (cyc <= 104) begin
      wlast = (cyc == 104);
      chk("w_beat_wready", wready, 1);
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("w_after_last_wready", wready, 0);
    until_cyc(123);
    chk("b_not_early", bvalid, 0);
    step();
    chk("b_bvalid", bvalid, 1);
    chk("b_bid",    bid,    3);
    until_cyc(130);
    chk("b_hold_bvalid", bvalid, 1);
    chk("b_hold_bid",    bid,    3);
    bready = 1'b1;
    step();
    chk("b_popped", bvalid, 0);
    bready = 1'b0;

    // Timestamp wrap: AR at now=250 -> response at now=14 (cycle 270)
    until_cyc(250);
    arvalid = 1'b1; arid = 4'd9; arlen = 8'd0;
    rready = 1'b1;
    chk("wrap_arready", arready, 1);
    step();
    arvalid = 1'b0;
    seen = 1'b0;
    while (cyc < 270) begin
      if (rvalid) seen = 1'b1;
      step();
    end
    chk("wrap_no_early", seen, 0);
    chk("wrap_rvalid", rvalid, 1);
    chk("wrap_rid",    rid,    9);
    chk("wrap_rlast",  rlast,  1);
    step();
    chk("wrap_done", rvalid, 0);

    // Reset mid-burst with a B response still pending
    until_cyc(280);
    arvalid = 1'b1; arid = 4'd2; arlen = 8'd3;
    awvalid = 1'b1; awid = 4'd6;
    step();
    arvalid = 1'b0; awvalid = 1'b0;
    until_cyc(290);
    wvalid = 1'b1; wlast = 1'b1;
    chk("rr_wready", wready, 1);
    step();
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    until_cyc(300);
    chk("rr_beat0_rvalid", rvalid, 1);
    chk("rr_beat0_rid",    rid,    2);
    until_cyc(302);
    chk("rr_beat2_rvalid", rvalid, 1);
    chk("rr_beat2_rlast",  rlast,  0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_rvalid",  rvalid,  0);
    chk("rr_rlast",   rlast,   0);
    chk("rr_arready", arready, 1);
    chk("rr_awready", awready, 1);
    chk("rr_wready",  wready,  0);
    chk("rr_bvalid",  bvalid,  0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rvalid || bvalid) seen = 1'b1;
      step();
    end
    chk("rr_no_responses", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/emulib_rammodel_timing_model_latency.md
# emulib_rammodel_timing_model_latency

Parametrised fixed-latency AXI timing model for the RAM model: accepts AR/AW/W control traffic from the emulated master and times the R/B responses. Read and write latency are independent, burst beats are generated with an explicit `rlast`, and outstanding transactions are bounded per channel. It slots into the RAM model wherever the fixed timing model is instantiated and carries no data, only IDs and timing.

## Interface
- `ADDR_WIDTH`, 32, address width (accepted, unused for timing)
- `ID_WIDTH`, 4, AXI ID width
- `MAX_R_INFLIGHT`, 8, read queue depth; power of two, ≥2
- `MAX_W_INFLIGHT`, 8, write queue depth; power of two, ≥2
- `R_LATENCY`, 20, cycles from AR handshake to first `rvalid`; 1 ≤ value < 2^(TS_WIDTH-1)
- `W_LATENCY`, 20, cycles from `wlast` handshake to `bvalid`; same range
- `TS_WIDTH`, 32, timestamp counter width
- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `arvalid`/`arready` in/out 1: AR handshake
- `arid` in ID_WIDTH; `araddr` in ADDR_WIDTH; `arlen` in 8; `arsize` in 3; `arburst` in 2
- `awvalid`/`awready` in/out 1: AW handshake
- `awid` in ID_WIDTH; `awaddr` in ADDR_WIDTH; `awlen` in 8; `awsize` in 3; `awburst` in 2
- `wvalid`/`wready` in/out 1: W beat handshake; `wlast` in 1
- `bvalid` out 1; `bready` in 1; `bid` out ID_WIDTH
- `rvalid` out 1; `rready` in 1; `rid` out ID_WIDTH; `rlast` out 1: final beat of burst

## Operation
- Free-running `now` counter, TS_WIDTH bits, +1 per cycle, wraps. Ready test: `$signed(now - t) >= 0` (TS_WIDTH-bit subtraction). This is wrap-safe while latency < 2^(TS_WIDTH-1).
- Read queue: circular FIFO of {id, len, t}, depth MAX_R_INFLIGHT.
  - `arready = (r_count != MAX_R_INFLIGHT)`. Registered count: an entry freed in the same cycle does not make room that cycle.
  - On AR handshake in cycle T, push {arid, arlen, T+R_LATENCY}.
- Read emit: when the head is valid and ready, assert `rvalid` with `rid` = head id.
  - A beat counter counts handshakes.
  - `rlast = rvalid && (beat == len)`.
  - On the last handshake: pop, and reset the beat counter to 0.
  - Responses are in-order across all IDs.
- Write queue: circular FIFO of {id, t, done}, depth MAX_W_INFLIGHT, with three pointers: aw_ptr (push), w_ptr (next entry awaiting data), b_ptr (pop).
  - `awready = (w_count != MAX_W_INFLIGHT)`.
- W handling is AW-first: `wready = (w_ptr != aw_ptr)`, i.e. only when an accepted AW has no completed data yet.
  - W beats before their AW are stalled.
  - `awlen` is not checked; `wlast` alone terminates the data.
  - On a `wlast` handshake in cycle T: set the entry's t = T+W_LATENCY and done=1, and advance w_ptr.
- B emit: `bvalid` when the b_ptr entry has done=1 and is ready; `bid` = entry id. On B handshake, pop and clear done.
- Simultaneous AR push and R pop, or AW push, W completion and B pop, in one cycle: all take effect; counts update by net change.
- Outputs hold stable while valid and not ready (AXI rules). `rid`, `rlast` and `bid` are don't-care when the corresponding valid is low.
- `araddr`, `awaddr`, size and burst inputs are ignored.

## Timing
- Reset values: `arready=1`, `awready=1`, `wready=0`, `rvalid=0`, `rlast=0`, `bvalid=0`, `now=0`. All queues are empty and all pointers 0.
- Reset mid-operation drops all in-flight transactions with no responses emitted. Outputs take their reset values in the cycle after `rst` is sampled high.
- First `rvalid` appears exactly R_LATENCY cycles after the AR handshake cycle if the queue head is free. Otherwise it appears at max(that, cycle after previous burst's last beat).
- Back-to-back beats: one per cycle with `rready` held high. A following burst whose t has passed starts in the cycle after the previous `rlast` handshake, with no bubble.
- `bvalid` appears exactly W_LATENCY cycles after the `wlast` handshake, subject to in-order B.
- All outputs are driven from registers or from registered state only; no combinational path from `*ready`/`*valid` inputs to outputs.

## Test plan
- R_LATENCY=20: single AR at cycle 10, arlen=3, id=5, rready=1 → `rvalid` cycles 30–33, rid=5 each beat, `rlast` only at cycle 33.
- MAX_R_INFLIGHT=8: 9 ARs issued back-to-back, rready=0 → `arready` low after the 8th handshake. First `rlast` handshake → `arready` high the following cycle. 9th AR is accepted, and its response follows in order.
- W_LATENCY=20: AW id=3 at cycle 5, W beats cycles 6–9 with wlast at 9 → `bvalid` at cycle 29, bid=3. With bready=0, `bvalid`/`bid` hold until bready.
- W before AW: wvalid asserted with no AW → `wready` stays 0. AW accepted → `wready=1` next cycle.
- TS_WIDTH=8, R_LATENCY=20: AR issued at now=250 → `rvalid` 20 cycles later, with `now` wrapped to 14; no early or missing response.
- Reset mid-burst: beat 2 of 4 is in flight when `rst` is pulsed for 1 cycle → next cycle `rvalid=0`, `arready=1`, and no further beats or B responses.
